// File: rtl/prewish5k_mask_sequencer_if.sv
// Controller-side bus of the mask sequencer: append port, run/clear controls,
// and the strobe/mask handshake toward the mentor plus playlist status.
interface prewish5k_mask_sequencer_if #(
  parameter int DEPTH_BITS = 3
);
  logic                  STB_I;
  logic [7:0]            DAT_I;
  logic                  i_clear;
  logic                  i_run;
  logic                  STB_O;
  logic [7:0]            DAT_O;
  logic [DEPTH_BITS:0]   o_count;
  logic                  o_full;
  logic                  o_alive;

  modport master (
    output STB_I, DAT_I, i_clear, i_run,
    input  STB_O, DAT_O, o_count, o_full, o_alive
  );

  modport slave (
    input  STB_I, DAT_I, i_clear, i_run,
    output STB_O, DAT_O, o_count, o_full, o_alive
  );
endinterface

// File: rtl/prewish5k_mask_sequencer.sv
// Playlist scheduler: stores up to 2**DEPTH_BITS blink masks and replays them
// round-robin, one STB_O/DAT_O strobe every DWELL_CYCLES clocks while running.
module prewish5k_mask_sequencer #(
  parameter int DEPTH_BITS   = 3,
  parameter int DWELL_CYCLES = 12_000_000,
  parameter int DWELL_BITS   = 24
) (
  input  logic                          CLK_I,
  input  logic                          RST_I,
  prewish5k_mask_sequencer_if.slave     bus
);
  localparam int                    ENTRIES    = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   FULL_COUNT = (DEPTH_BITS + 1)'(ENTRIES);
  localparam logic [DWELL_BITS-1:0] DWELL_LOAD = DWELL_BITS'(DWELL_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DWELL
  } state_t;

  state_t                  state_q, state_n;
  logic                    stb_q, stb_n;
  logic [7:0]              dat_q, dat_n;
  logic [DEPTH_BITS:0]     count_q, count_n;
  logic [DEPTH_BITS-1:0]   idx_q, idx_n;
  logic [DWELL_BITS-1:0]   dwell_q, dwell_n;

  logic [7:0]              mem [ENTRIES];
  logic                    full;
  logic                    wr_en;
  logic [DEPTH_BITS:0]     idx_inc;
  logic [DEPTH_BITS-1:0]   idx_adv;

  assign full    = (count_q == FULL_COUNT);
  assign wr_en   = bus.STB_I && !full && !bus.i_clear;
  // Wrap decision uses the pre-edge count, so a same-edge append waits a lap.
  assign idx_inc = {1'b0, idx_q} + 1'b1;
  assign idx_adv = (idx_inc >= count_q) ? '0 : idx_inc[DEPTH_BITS-1:0];

  // NOTE: the playlist storage has no reset; only count/idx define validity,
  // which keeps it a plain RAM without a reset fan-out to every entry.
  always_ff @(posedge CLK_I) begin
    if (wr_en) mem[count_q[DEPTH_BITS-1:0]] <= bus.DAT_I;
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_n = state_q;
    stb_n   = stb_q;
    dat_n   = dat_q;
    count_n = count_q;
    idx_n   = idx_q;
    dwell_n = dwell_q;

    if (bus.i_clear) begin
      count_n = '0;
      idx_n   = '0;
      state_n = IDLE;
      stb_n   = 1'b0;
    end else begin
      if (wr_en) count_n = count_q + 1'b1;

      unique case (state_q)
        IDLE: begin
          if (bus.i_run && count_q != '0) begin
            stb_n   = 1'b1;
            dat_n   = mem[idx_q];
            state_n = ISSUE;
          end
        end
        ISSUE: begin
          stb_n   = 1'b0;
          dwell_n = DWELL_LOAD;
          state_n = DWELL;
        end
        DWELL: begin
          if (dwell_q != '0) begin
            dwell_n = dwell_q - 1'b1;
          end else begin
            idx_n = idx_adv;
            if (bus.i_run && count_q != '0) begin
              stb_n   = 1'b1;
              dat_n   = mem[idx_adv];
              state_n = ISSUE;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      dat_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_n;
      stb_q   <= stb_n;
      dat_q   <= dat_n;
      count_q <= count_n;
      idx_q   <= idx_n;
      dwell_q <= dwell_n;
    end
  end

  assign bus.STB_O   = stb_q;
  assign bus.DAT_O   = dat_q;
  assign bus.o_count = count_q;
  assign bus.o_full  = full;
  assign bus.o_alive = (state_q != IDLE);
endmodule

// File: tb/tb_prewish5k_mask_sequencer.sv
// Bench for the mask sequencer: timeline model of the playlist checked every
// cycle, plus directed scenarios with literal expected masks and strobe gaps.
module tb_prewish5k_mask_sequencer;
  localparam int DB = 2;
  localparam int DW = 4;
  localparam int NENT = 1 << DB;

  logic CLK_I = 1'b0;
  logic RST_I;
  always #5 CLK_I = ~CLK_I;

  prewish5k_mask_sequencer_if #(.DEPTH_BITS(DB)) bus ();

  prewish5k_mask_sequencer #(
    .DEPTH_BITS  (DB),
    .DWELL_CYCLES(DW),
    .DWELL_BITS  (4)
  ) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: playlist array, rotation pointer, and edges elapsed since the last strobe.
  logic [7:0] m_mem [NENT];
  int         m_count = 0;
  int         m_idx   = 0;
  int         m_age   = 0;
  bit         m_active = 0;
  bit         m_stb    = 0;
  logic [7:0] m_dat    = 8'h00;
  bit         armed    = 0;

  always @(posedge CLK_I) begin : model
    int pre;
    pre = m_count;
    if (RST_I) begin
      m_count = 0; m_idx = 0; m_age = 0; m_active = 0; m_stb = 0; m_dat = 8'h00;
      armed = 1;
    end else begin
      m_stb = 0;
      if (bus.i_clear) begin
        m_count = 0; m_idx = 0; m_active = 0;
      end else begin
        if (!m_active) begin
          if (bus.i_run && pre != 0) begin
            m_stb = 1; m_dat = m_mem[m_idx]; m_active = 1; m_age = 0;
          end
        end else begin
          m_age++;
          if (m_age == DW) begin
            m_idx = (m_idx + 1) % pre;
            if (bus.i_run && pre != 0) begin
              m_stb = 1; m_dat = m_mem[m_idx]; m_age = 0;
            end else begin
              m_active = 0;
            end
          end
        end
        if (bus.STB_I && pre < NENT) begin
          m_mem[pre] = bus.DAT_I;
          m_count = pre + 1;
        end
      end
    end
  end

  always @(negedge CLK_I) begin
    if (armed) begin
      check("cyc_stb",   bus.STB_O,   m_stb);
      check("cyc_dat",   bus.DAT_O,   m_dat);
      check("cyc_count", bus.o_count, m_count);
      check("cyc_full",  bus.o_full,  m_count == NENT);
      check("cyc_alive", bus.o_alive, m_active);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK_I);
  endtask

  task automatic push(input logic [7:0] d);
    bus.STB_I = 1'b1;
    bus.DAT_I = d;
    tick();
    bus.STB_I = 1'b0;
  endtask

  task automatic wait_strobe(output logic [7:0] d, output int waited);
    waited = 0;
    d = 8'h00;
    do begin
      tick();
      waited++;
    end while (!bus.STB_O && waited < 60);
    if (!bus.STB_O) check("strobe_timeout", bus.STB_O, 1);
    else d = bus.DAT_O;
  endtask

  task automatic count_strobes(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      tick();
      if (bus.STB_O) seen++;
    end
  endtask

  task automatic stop_and_clear();
    int k;
    bus.i_run = 1'b0;
    k = 0;
    while (bus.o_alive && k < 20) begin
      tick();
      k++;
    end
    check("stop_idle", bus.o_alive, 0);
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] last;
    int w;
    int seen;
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [5];
    exp1 = '{8'h81, 8'h42, 8'h24, 8'h81};
    exp2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01};

    bus.STB_I = 0; bus.DAT_I = 0; bus.i_clear = 0; bus.i_run = 0;
    RST_I = 1'b1;
    tick(2);
    RST_I = 1'b0;
    tick();
    check("rst_count", bus.o_count, 0);
    check("rst_stb",   bus.STB_O,   0);
    check("rst_dat",   bus.DAT_O,   0);
    check("rst_alive", bus.o_alive, 0);

    // 1: three entries replayed every DW clocks
    push(8'h81); push(8'h42); push(8'h24);
    check("t1_count", bus.o_count, 3);
    bus.i_run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(d, w);
      check("t1_dat", d, exp1[i]);
      if (i == 0) check("t1_latency", w, 1);
      else        check("t1_gap", w, DW);
    end
    stop_and_clear();

    // 2: fifth append dropped when full
    for (int i = 1; i <= 5; i++) push(8'(i));
    check("t2_count", bus.o_count, 4);
    check("t2_full",  bus.o_full, 1);
    bus.i_run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(d, w);
      check("t2_dat", d, exp2[i]);
    end
    stop_and_clear();

    // 3: run with empty playlist never strobes
    bus.i_run = 1'b1;
    count_strobes(20, seen);
    check("t3_strobes", seen, 0);
    check("t3_alive", bus.o_alive, 0);
    bus.i_run = 1'b0;
    tick();

    // 4: drop run after the 0x42 pulse, resume at 0x24
    push(8'h81); push(8'h42); push(8'h24);
    bus.i_run = 1'b1;
    wait_strobe(d, w);
    check("t4_first", d, 8'h81);
    wait_strobe(d, w);
    check("t4_second", d, 8'h42);
    tick();
    bus.i_run = 1'b0;
    count_strobes(12, seen);
    check("t4_no_strobe", seen, 0);
    check("t4_idle", bus.o_alive, 0);
    bus.i_run = 1'b1;
    wait_strobe(d, w);
    check("t4_resume", d, 8'h24);

    // 5: clear beats same-cycle append mid-dwell
    wait_strobe(d, w);
    check("t5_pre", d, 8'h81);
    last = d;
    tick(2);
    bus.i_clear = 1'b1; bus.STB_I = 1'b1; bus.DAT_I = 8'h99;
    tick();
    bus.i_clear = 1'b0; bus.STB_I = 1'b0;
    check("t5_count", bus.o_count, 0);
    check("t5_stb",   bus.STB_O, 0);
    check("t5_alive", bus.o_alive, 0);
    check("t5_dat",   bus.DAT_O, last);
    count_strobes(8, seen);
    check("t5_no_strobe", seen, 0);
    bus.i_run = 1'b0;
    tick();

    // 6: reset mid-run
    push(8'h11); push(8'h22);
    bus.i_run = 1'b1;
    wait_strobe(d, w);
    check("t6_first", d, 8'h11);
    tick(2);
    RST_I = 1'b1;
    tick();
    RST_I = 1'b0;
    check("t6_stb",   bus.STB_O, 0);
    check("t6_dat",   bus.DAT_O, 0);
    check("t6_count", bus.o_count, 0);
    check("t6_alive", bus.o_alive, 0);
    bus.i_run = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
